// File: rtl/grid_raster_gen.sv
// Procedural tic-tac-toe grid raster: running cell/offset counters plus a two-stage output pipe.
// Define GRID_BORDER_EN to also draw the outer border of the grid.
module grid_raster_gen #(
    parameter int unsigned CELL_PX = 80,
    parameter int unsigned LINE_PX = 1,
    parameter int unsigned GRID_N  = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_start_i,
    input  logic                         line_start_i,
    input  logic                         pix_valid_i,
    output logic                         pix_valid_o,
    output logic                         pix_bit_o,
    output logic                         in_grid_o,
    output logic [$clog2(GRID_N+1)-1:0]  cell_col_o,
    output logic [$clog2(GRID_N+1)-1:0]  cell_row_o,
    output logic [$clog2(CELL_PX)-1:0]   cell_u_o,
    output logic [$clog2(CELL_PX)-1:0]   cell_v_o
);
    localparam int unsigned CW = $clog2(GRID_N + 1);
    localparam int unsigned UW = $clog2(CELL_PX);
    localparam logic [UW-1:0] U_LAST = UW'(CELL_PX - 1);
    localparam logic [UW-1:0] U_EDGE = UW'(CELL_PX - LINE_PX);
    localparam logic [CW-1:0] C_SAT  = CW'(GRID_N);
    localparam logic [CW-1:0] C_LAST = CW'(GRID_N - 1);
`ifdef GRID_BORDER_EN
    localparam logic [UW-1:0] U_LINE = UW'(LINE_PX);
`endif

    logic [UW-1:0] u_q, u_d, v_q, v_d;
    logic [CW-1:0] col_q, col_d, row_q, row_d;
    logic          first_line_q, first_line_d;

    logic          s1_valid_q, s1_valid_d;
    logic [UW-1:0] s1_u_q, s1_u_d, s1_v_q, s1_v_d;
    logic [CW-1:0] s1_col_q, s1_col_d, s1_row_q, s1_row_d;

    logic          pix_valid_q, pix_valid_d, pix_bit_q, pix_bit_d, in_grid_q, in_grid_d;
    logic [CW-1:0] cell_col_q, cell_col_d, cell_row_q, cell_row_d;
    logic [UW-1:0] cell_u_q, cell_u_d, cell_v_q, cell_v_d;

    logic          in_grid, line_hit;

    // Start pulses resolve first; a pixel in the same cycle takes the post-start coordinates.
    always_comb begin
        u_d          = u_q;
        col_d        = col_q;
        v_d          = v_q;
        row_d        = row_q;
        first_line_d = first_line_q;
        if (frame_start_i) begin
            u_d          = '0;
            col_d        = '0;
            v_d          = '0;
            row_d        = '0;
            first_line_d = 1'b1;
        end else if (line_start_i) begin
            u_d   = '0;
            col_d = '0;
            if (first_line_q) begin
                first_line_d = 1'b0;
            end else if (v_q == U_LAST) begin
                v_d = '0;
                if (row_q != C_SAT) row_d = row_q + 1'b1;
            end else begin
                v_d = v_q + 1'b1;
            end
        end

        s1_valid_d = pix_valid_i;
        s1_u_d     = s1_u_q;
        s1_col_d   = s1_col_q;
        s1_v_d     = s1_v_q;
        s1_row_d   = s1_row_q;
        if (pix_valid_i) begin
            s1_u_d   = u_d;
            s1_col_d = col_d;
            s1_v_d   = v_d;
            s1_row_d = row_d;
            if (u_d == U_LAST) begin
                u_d = '0;
                if (col_d != C_SAT) col_d = col_d + 1'b1;
            end else begin
                u_d = u_d + 1'b1;
            end
        end
    end

    always_comb begin
        in_grid  = (s1_col_q < C_SAT) && (s1_row_q < C_SAT);
        line_hit = ((s1_u_q >= U_EDGE) && (s1_col_q < C_LAST)) ||
                   ((s1_v_q >= U_EDGE) && (s1_row_q < C_LAST));
`ifdef GRID_BORDER_EN
        line_hit = line_hit ||
                   ((s1_col_q == '0) && (s1_u_q < U_LINE)) ||
                   ((s1_row_q == '0) && (s1_v_q < U_LINE)) ||
                   ((s1_col_q == C_LAST) && (s1_u_q >= U_EDGE)) ||
                   ((s1_row_q == C_LAST) && (s1_v_q >= U_EDGE));
`endif
        pix_valid_d = s1_valid_q;
        pix_bit_d   = pix_bit_q;
        in_grid_d   = in_grid_q;
        cell_col_d  = cell_col_q;
        cell_row_d  = cell_row_q;
        cell_u_d    = cell_u_q;
        cell_v_d    = cell_v_q;
        if (s1_valid_q) begin
            pix_bit_d  = ~(in_grid && line_hit);
            in_grid_d  = in_grid;
            cell_col_d = s1_col_q;
            cell_row_d = s1_row_q;
            cell_u_d   = s1_u_q;
            cell_v_d   = s1_v_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            u_q          <= '0;
            col_q        <= '0;
            v_q          <= '0;
            row_q        <= '0;
            first_line_q <= 1'b1;
            s1_valid_q   <= 1'b0;
            s1_u_q       <= '0;
            s1_col_q     <= '0;
            s1_v_q       <= '0;
            s1_row_q     <= '0;
            pix_valid_q  <= 1'b0;
            pix_bit_q    <= 1'b1;
            in_grid_q    <= 1'b0;
            cell_col_q   <= '0;
            cell_row_q   <= '0;
            cell_u_q     <= '0;
            cell_v_q     <= '0;
        end else begin
            u_q          <= u_d;
            col_q        <= col_d;
            v_q          <= v_d;
            row_q        <= row_d;
            first_line_q <= first_line_d;
            s1_valid_q   <= s1_valid_d;
            s1_u_q       <= s1_u_d;
            s1_col_q     <= s1_col_d;
            s1_v_q       <= s1_v_d;
            s1_row_q     <= s1_row_d;
            pix_valid_q  <= pix_valid_d;
            pix_bit_q    <= pix_bit_d;
            in_grid_q    <= in_grid_d;
            cell_col_q   <= cell_col_d;
            cell_row_q   <= cell_row_d;
            cell_u_q     <= cell_u_d;
            cell_v_q     <= cell_v_d;
        end
    end

    assign pix_valid_o = pix_valid_q;
    assign pix_bit_o   = pix_bit_q;
    assign in_grid_o   = in_grid_q;
    assign cell_col_o  = cell_col_q;
    assign cell_row_o  = cell_row_q;
    assign cell_u_o    = cell_u_q;
    assign cell_v_o    = cell_v_q;

endmodule

// File: tb/tb_grid_raster_gen.sv
// Scoreboard bench for grid_raster_gen: two instances (LINE_PX 1 and 4) share one random stimulus
// stream; a frame-coordinate model (x, y with div/mod) predicts every output pixel.
module tb_grid_raster_gen;
    localparam int CELL = 80;
    localparam int N    = 3;

    typedef struct {
        logic b;
        logic g;
        int   col;
        int   row;
        int   u;
        int   v;
    } exp_t;

    typedef struct {
        longint due;
        int     x;
        int     y;
        exp_t   e1;
        exp_t   e4;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic frame_start = 1'b0, line_start = 1'b0, pix_valid = 1'b0;

    logic       v1, b1, g1, v4, b4, g4;
    logic [1:0] c1, r1, c4, r4;
    logic [6:0] u1, w1, u4, w4;

    int   checks = 0;
    int   failures = 0;
    ent_t q[$];
    int   mx = 0, my = 0;
    bit   mfirst = 1'b1;

    always #5 clk = ~clk;

    grid_raster_gen #(.CELL_PX(80), .LINE_PX(1), .GRID_N(3)) d1 (
        .clk(clk), .reset(reset), .frame_start_i(frame_start), .line_start_i(line_start),
        .pix_valid_i(pix_valid), .pix_valid_o(v1), .pix_bit_o(b1), .in_grid_o(g1),
        .cell_col_o(c1), .cell_row_o(r1), .cell_u_o(u1), .cell_v_o(w1)
    );

    grid_raster_gen #(.CELL_PX(80), .LINE_PX(4), .GRID_N(3)) d4 (
        .clk(clk), .reset(reset), .frame_start_i(frame_start), .line_start_i(line_start),
        .pix_valid_i(pix_valid), .pix_valid_o(v4), .pix_bit_o(b4), .in_grid_o(g4),
        .cell_col_o(c4), .cell_row_o(r4), .cell_u_o(u4), .cell_v_o(w4)
    );

    function automatic exp_t model(int x, int y, int lp);
        exp_t e;
        bit   hit;
        e.col = (x / CELL > N) ? N : x / CELL;
        e.row = (y / CELL > N) ? N : y / CELL;
        e.u   = x % CELL;
        e.v   = y % CELL;
        e.g   = (e.col < N) && (e.row < N);
        hit   = (e.u >= CELL - lp && e.col < N - 1) || (e.v >= CELL - lp && e.row < N - 1);
`ifdef GRID_BORDER_EN
        hit = hit || (e.col == 0 && e.u < lp) || (e.row == 0 && e.v < lp) ||
              (e.col == N - 1 && e.u >= CELL - lp) || (e.row == N - 1 && e.v >= CELL - lp);
`endif
        e.b = !(e.g && hit);
        return e;
    endfunction

    function automatic bit same(logic b, logic g, int c, int r, int u, int v, exp_t e);
        return b == e.b && g == e.g && c == e.col && r == e.row && u == e.u && v == e.v;
    endfunction

    task automatic step(input logic f, input logic l, input logic p);
        ent_t n;
        @(posedge clk);
        #1;
        frame_start = f;
        line_start  = l;
        pix_valid   = p;
        if (f) begin
            mx = 0; my = 0; mfirst = 1'b1;
        end else if (l) begin
            mx = 0;
            if (mfirst) mfirst = 1'b0;
            else my++;
        end
        if (p) begin
            n.due = longint'($time) + 20;
            n.x   = mx;
            n.y   = my;
            n.e1  = model(mx, my, 1);
            n.e4  = model(mx, my, 4);
            q.push_back(n);
            mx++;
        end
    endtask

    task automatic line_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic chk_reset(input string name);
        checks++;
        if (v1 !== 1'b0 || b1 !== 1'b1 || g1 !== 1'b0 || c1 !== 2'd0 || r1 !== 2'd0 ||
            u1 !== 7'd0 || w1 !== 7'd0 || v4 !== 1'b0 || b4 !== 1'b1 || g4 !== 1'b0 ||
            c4 !== 2'd0 || r4 !== 2'd0 || u4 !== 7'd0 || w4 !== 7'd0) begin
            failures++;
            $display("FAIL %s: got v=%b/%b bit=%b/%b grid=%b/%b col=%0d/%0d row=%0d/%0d u=%0d/%0d v=%0d/%0d, want v=0 bit=1 grid=0 rest 0",
                     name, v1, v4, b1, b4, g1, g4, c1, c4, r1, r4, u1, u4, w1, w4);
        end
    endtask

    // Monitor: pops one expectation per presented pixel and checks timing and every field.
    initial begin
        ent_t e;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0 && q[0].due < longint'($time)) begin
                e = q.pop_front();
                checks++;
                failures++;
                $display("FAIL missing_pixel x=%0d y=%0d: no output at t=%0d", e.x, e.y, e.due);
            end
            if (v1 || v4) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL spurious_valid t=%0t: v=%b/%b with nothing expected", $time, v1, v4);
                end else begin
                    e = q.pop_front();
                    if (e.due != longint'($time) || !v1 || !v4 ||
                        !same(b1, g1, int'(c1), int'(r1), int'(u1), int'(w1), e.e1) ||
                        !same(b4, g4, int'(c4), int'(r4), int'(u4), int'(w4), e.e4)) begin
                        failures++;
                        $display("FAIL pixel x=%0d y=%0d t=%0t due=%0d v=%b/%b got L1 bit=%b grid=%b col=%0d row=%0d u=%0d v=%0d L4 bit=%b grid=%b col=%0d row=%0d u=%0d v=%0d want L1 bit=%b grid=%b col=%0d row=%0d u=%0d v=%0d L4 bit=%b",
                                 e.x, e.y, $time, e.due, v1, v4, b1, g1, c1, r1, u1, w1,
                                 b4, g4, c4, r4, u4, w4, e.e1.b, e.e1.g, e.e1.col, e.e1.row,
                                 e.e1.u, e.e1.v, e.e4.b);
                    end
                end
            end
        end
    end

    initial begin
        #12;
        chk_reset("reset_state");
        reset = 1'b0;

        // Structured frame: combined start with a pixel, then lines until past the grid bottom.
        step(1'b1, 1'b1, 1'b1);
        line_pixels(241);
        while (my < 242) begin
            step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
            if (my <= 2 || my == 79 || my == 80 || my == 81 || my == 159 || my == 160 ||
                my >= 239)
                line_pixels(242 - mx);
            else
                line_pixels($urandom_range(1, 12));
        end
        step(1'b0, 1'b0, 1'b0);

        // Random pulses and gapped strobes.
        for (int i = 0; i < 4000; i++) begin
            step(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 59) == 0),
                 1'($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset mid-line.
        step(1'b1, 1'b1, 1'b1);
        line_pixels(30);
        #3;
        reset = 1'b1;
        #1;
        chk_reset("async_reset");
        q.delete();
        mx = 0; my = 0; mfirst = 1'b1;
        frame_start = 1'b0; line_start = 1'b0; pix_valid = 1'b0;
        #1;
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d pixels never produced, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
